// File: rtl/ir_fetch_decode.sv
// Instruction fetch over a req/ack memory port and ARM decode into a one-hot
// command vector plus the field outputs consumed by the multi-cycle controller.
module ir_fetch_decode #(
    parameter int AW          = 32,
    parameter int CMD_W       = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_ir,
    input  logic             flush,
    input  logic [AW-1:0]    pc,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             W_IR_valid,
    output logic             fetch_fault,
    output logic [31:0]      ir,
    output logic [CMD_W-1:0] command,
    output logic             rm_imm_s,
    output logic [1:0]       rs_imm_s,
    output logic [2:0]       SHIFT_OP,
    output logic [3:0]       ALU_OP,
    output logic             S,
    output logic             P,
    output logic             U,
    output logic             W,
    output logic [1:0]       v_type
);

    localparam int CMD_DP    = 0;
    localparam int CMD_BX    = 1;
    localparam int CMD_B     = 2;
    localparam int CMD_BL    = 3;
    localparam int CMD_LDR0  = 4;
    localparam int CMD_LDR1  = 5;
    localparam int CMD_STR0  = 6;
    localparam int CMD_STR1  = 7;
    localparam int CMD_SWP   = 8;
    localparam int CMD_UNDEF = CMD_W - 1;
    localparam logic [CMD_W-1:0] UNDEF_CMD = {1'b1, {(CMD_W-1){1'b0}}};

    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, REQ, DECODE, FAULT} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic [CMD_W-1:0] dec_cmd;
    logic             dec_is_dp;
    logic             dec_swp;

    // The last allowed wait cycle is the one where the counter has seen ACK_TIMEOUT-1 misses.
    assign timeout = (ACK_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (write_ir && !flush) next_state = REQ;
            end
            REQ: begin
                if (flush)         next_state = IDLE;
                else if (imem_ack) next_state = DECODE;
                else if (timeout)  next_state = FAULT;
            end
            DECODE:  next_state = IDLE;
            FAULT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state == REQ);
        W_IR_valid  = ((state == DECODE) || (state == FAULT)) && !flush;
        fetch_fault = (state == FAULT) && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != REQ) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr <= '0;
        end else if (state == IDLE && write_ir && !flush) begin
            imem_addr <= pc;
        end
    end

    assign dec_swp = (imem_rdata[27:23] == 5'b00010) && (imem_rdata[21:20] == 2'b00)
                     && (imem_rdata[11:4] == 8'h09);

    // Priority order matters: BX and SWP live inside the DP encoding space.
    always_comb begin
        dec_cmd   = '0;
        dec_is_dp = 1'b0;
        if (imem_rdata[27:4] == 24'h12FFF1) begin
            dec_cmd[CMD_BX] = 1'b1;
        end else if (dec_swp) begin
            dec_cmd[CMD_SWP] = 1'b1;
        end else if (imem_rdata[27:25] == 3'b101) begin
            if (imem_rdata[24]) dec_cmd[CMD_BL] = 1'b1;
            else                dec_cmd[CMD_B]  = 1'b1;
        end else if (imem_rdata[27:26] == 2'b01) begin
            case ({imem_rdata[25], imem_rdata[20]})
                2'b01:   dec_cmd[CMD_LDR0] = 1'b1;
                2'b11:   dec_cmd[CMD_LDR1] = 1'b1;
                2'b00:   dec_cmd[CMD_STR0] = 1'b1;
                default: dec_cmd[CMD_STR1] = 1'b1;
            endcase
        end else if (imem_rdata[27:26] == 2'b00
                     && !(!imem_rdata[25] && imem_rdata[7] && imem_rdata[4])) begin
            dec_cmd[CMD_DP] = 1'b1;
            dec_is_dp       = 1'b1;
        end else begin
            dec_cmd[CMD_UNDEF] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            command  <= '0;
            rm_imm_s <= 1'b0;
            rs_imm_s <= 2'b00;
            SHIFT_OP <= 3'b000;
            ALU_OP   <= 4'b0000;
            S        <= 1'b0;
            P        <= 1'b0;
            U        <= 1'b0;
            W        <= 1'b0;
            v_type   <= 2'b00;
        end else if (state == REQ && next_state == DECODE) begin
            ir       <= imem_rdata;
            command  <= dec_cmd;
            rm_imm_s <= dec_is_dp && imem_rdata[25];
            rs_imm_s <= !dec_is_dp ? 2'b00 : (imem_rdata[25] ? 2'b10 : {1'b0, imem_rdata[4]});
            SHIFT_OP <= (dec_is_dp && imem_rdata[25]) ? 3'b111 : {imem_rdata[6:5], imem_rdata[4]};
            ALU_OP   <= dec_is_dp ? imem_rdata[24:21] : 4'b0000;
            S        <= dec_is_dp && imem_rdata[20];
            P        <= imem_rdata[24];
            U        <= imem_rdata[23];
            W        <= imem_rdata[21];
            v_type   <= imem_rdata[6:5];
        end else if (state == REQ && next_state == FAULT) begin
            command  <= UNDEF_CMD;
            rm_imm_s <= 1'b0;
            rs_imm_s <= 2'b00;
            SHIFT_OP <= 3'b000;
            ALU_OP   <= 4'b0000;
            S        <= 1'b0;
            P        <= 1'b0;
            U        <= 1'b0;
            W        <= 1'b0;
            v_type   <= 2'b00;
        end
    end

endmodule

// File: tb/tb_ir_fetch_decode.sv
// Directed bench for ir_fetch_decode: expected decodes are queued when the ack
// data is driven and compared by a monitor whenever W_IR_valid pulses.
module tb_ir_fetch_decode;

    localparam int AW    = 32;
    localparam int CMD_W = 64;
    localparam int TO    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             write_ir = 1'b0;
    logic             flush = 1'b0;
    logic [AW-1:0]    pc = '0;
    logic             imem_req;
    logic [AW-1:0]    imem_addr;
    logic             imem_ack = 1'b0;
    logic [31:0]      imem_rdata = '0;
    logic             W_IR_valid;
    logic             fetch_fault;
    logic [31:0]      ir;
    logic [CMD_W-1:0] command;
    logic             rm_imm_s;
    logic [1:0]       rs_imm_s;
    logic [2:0]       SHIFT_OP;
    logic [3:0]       ALU_OP;
    logic             S, P, U, W;
    logic [1:0]       v_type;

    always #5 clk = ~clk;

    ir_fetch_decode #(.AW(AW), .CMD_W(CMD_W), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .write_ir(write_ir), .flush(flush), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .W_IR_valid(W_IR_valid), .fetch_fault(fetch_fault),
        .ir(ir), .command(command), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s),
        .SHIFT_OP(SHIFT_OP), .ALU_OP(ALU_OP), .S(S), .P(P), .U(U), .W(W), .v_type(v_type)
    );

    typedef struct {
        logic [63:0] cmd;
        logic [31:0] word;
        logic        chk_ir;
        logic [3:0]  alu;
        logic        s, p, u, w;
        logic [1:0]  vt;
        logic        rm;
        logic [1:0]  rs;
        logic [2:0]  sh;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic wir, input logic fl, input logic ack, input logic [31:0] data);
        write_ir   = wir;
        flush      = fl;
        imem_ack   = ack;
        imem_rdata = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic exp_t mk(input int idx, input logic [31:0] word, input logic [3:0] alu,
                                input logic s, input logic p, input logic u, input logic w,
                                input logic [1:0] vt, input logic rm, input logic [1:0] rs,
                                input logic [2:0] sh);
        exp_t e;
        e.cmd = 64'd1 << idx;
        e.word = word;
        e.chk_ir = 1'b1;
        e.alu = alu;
        e.s = s; e.p = p; e.u = u; e.w = w;
        e.vt = vt; e.rm = rm; e.rs = rs; e.sh = sh;
        e.fault = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && W_IR_valid === 1'b1) begin
            check_output("valid_has_expectation", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output("command", command, e.cmd);
                if (e.chk_ir) check_output("ir", ir, e.word);
                check_output("ALU_OP", ALU_OP, e.alu);
                check_output("S", S, e.s);
                check_output("P", P, e.p);
                check_output("U", U, e.u);
                check_output("W", W, e.w);
                check_output("v_type", v_type, e.vt);
                check_output("rm_imm_s", rm_imm_s, e.rm);
                check_output("rs_imm_s", rs_imm_s, e.rs);
                check_output("SHIFT_OP", SHIFT_OP, e.sh);
                check_output("fetch_fault", fetch_fault, e.fault);
            end
        end
    end

    // One complete fetch: request, optional wait states, ack, then back to IDLE.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int waits,
                            input bit toggle, input exp_t e);
        int req_cycles;
        pc = addr;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_output("req_rises", imem_req, 1'b1);
        check_output("imem_addr", imem_addr, addr);
        req_cycles = 1;
        for (int i = 0; i < waits; i++) begin
            apply_stimulus(toggle && i[0], 1'b0, 1'b0, 32'h0);
            tick();
            check_output("addr_stable", imem_addr, addr);
            check_output("valid_during_wait", W_IR_valid, 1'b0);
            if (imem_req) req_cycles++;
        end
        sb.push_back(e);
        apply_stimulus(1'b0, 1'b0, 1'b1, word);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_output("req_cycles", req_cycles, waits + 1);
        check_output("valid_after_ack", W_IR_valid, 1'b1);
        check_output("req_drops", imem_req, 1'b0);
        tick();
        check_output("valid_one_cycle", W_IR_valid, 1'b0);
        check_output("no_second_req", imem_req, 1'b0);
        check_output("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        exp_t fe;
        int   req_cycles;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check_output("rst_imem_req", imem_req, 1'b0);
        check_output("rst_valid", W_IR_valid, 1'b0);
        check_output("rst_fault", fetch_fault, 1'b0);
        check_output("rst_command", command, 64'h0);
        check_output("rst_ir", ir, 32'h0);
        check_output("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] zero-wait DP fetch");
        do_fetch(32'h100, 32'hE0821003, 0, 1'b0,
                 mk(0, 32'hE0821003, 4'b0100, 0, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000));

        $display("[TB] back-to-back decode classes");
        do_fetch(32'h104, 32'hE5910004, 0, 1'b0,
                 mk(4, 32'hE5910004, 4'b0000, 0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000));
        do_fetch(32'h108, 32'hE12FFF1E, 0, 1'b0,
                 mk(1, 32'hE12FFF1E, 4'b0000, 0, 1, 0, 1, 2'b00, 0, 2'b00, 3'b001));
        do_fetch(32'h10C, 32'hEA000002, 0, 1'b0,
                 mk(2, 32'hEA000002, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000));
        do_fetch(32'h110, 32'hEB000002, 0, 1'b0,
                 mk(3, 32'hEB000002, 4'b0000, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000));
        do_fetch(32'h114, 32'hE1010092, 0, 1'b0,
                 mk(8, 32'hE1010092, 4'b0000, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b001));
        do_fetch(32'h118, 32'hE0010392, 0, 1'b0,
                 mk(63, 32'hE0010392, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b001));
        do_fetch(32'h11C, 32'hE29000FF, 0, 1'b0,
                 mk(0, 32'hE29000FF, 4'b0100, 1, 0, 1, 0, 2'b11, 1, 2'b10, 3'b111));
        do_fetch(32'h120, 32'hE1A00351, 0, 1'b0,
                 mk(0, 32'hE1A00351, 4'b1101, 0, 1, 1, 1, 2'b10, 0, 2'b01, 3'b101));

        $display("[TB] ack delayed three cycles with write_ir toggling");
        do_fetch(32'h200, 32'hE7812003, 3, 1'b1,
                 mk(7, 32'hE7812003, 4'b0000, 0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000));

        $display("[TB] ack timeout");
        fe = mk(63, 32'h0, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000);
        fe.chk_ir = 1'b0;
        fe.fault  = 1'b1;
        sb.push_back(fe);
        pc = 32'h300;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        req_cycles = 0;
        for (int i = 0; i < 12 && imem_req; i++) begin
            req_cycles++;
            tick();
        end
        check_output("timeout_req_cycles", req_cycles, TO);
        check_output("timeout_fault", fetch_fault, 1'b1);
        check_output("timeout_valid", W_IR_valid, 1'b1);
        tick();
        check_output("fault_one_cycle", fetch_fault, 1'b0);
        check_output("fault_back_idle", imem_req, 1'b0);
        check_output("fault_drained", sb.size(), 0);

        $display("[TB] flush on the ack cycle");
        do_fetch(32'h400, 32'hE7812003, 0, 1'b0,
                 mk(7, 32'hE7812003, 4'b0000, 0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000));
        pc = 32'h404;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'hE0821003);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_output("flush_req_drop", imem_req, 1'b0);
        check_output("flush_no_valid", W_IR_valid, 1'b0);
        check_output("flush_ir_kept", ir, 32'hE7812003);
        check_output("flush_cmd_kept", command, 64'h80);
        tick();
        check_output("flush_still_quiet", W_IR_valid, 1'b0);

        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hEA000002);
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        check_output("idle_ack_ignored", ir, 32'hE7812003);
        check_output("idle_ack_no_valid", W_IR_valid, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_output("idle_flush_blocks_req", imem_req, 1'b0);

        $display("[TB] reset in the middle of a request");
        pc = 32'h500;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_output("pre_reset_req", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_req", imem_req, 1'b0);
        check_output("mid_rst_valid", W_IR_valid, 1'b0);
        check_output("mid_rst_ir", ir, 32'h0);
        check_output("mid_rst_command", command, 64'h0);
        check_output("mid_rst_addr", imem_addr, 32'h0);
        check_output("mid_rst_P", P, 1'b0);
        check_output("mid_rst_U", U, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_output("post_rst_idle", imem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
